// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream, writes
// big-endian 32-bit words to imem, and releases the CPU once the checksum matches.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  ImemWE,
   output logic [ADDR_WIDTH-1:0] ImemAddr,
   output logic [31:0]           ImemWData,
   output logic                  CpuRun,
   output logic                  LoadErr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_ERROR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [31:0]           data_q, data_d;
   logic [7:0]            acc_q, acc_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  run_q, run_d;
   logic                  err_q, err_d;

   logic                  xfer;
   logic                  is_sync;
   logic [15:0]           len_rx;
   logic                  len_bad;
   logic                  word_done;
   logic [ADDR_WIDTH:0]   word_inc;
   logic                  last_word;

   assign xfer      = ByteValid & ready_q;
   assign is_sync   = (ByteIn == SYNC_BYTE);
   assign len_rx    = {len_q[15:8], ByteIn};
   assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > MAX_WORDS);
   assign word_done = (byte_cnt_q == 2'd3);
   assign word_inc  = word_cnt_q + 1'b1;
   // The counter is one bit wider than the address so a full-depth frame ends cleanly.
   assign last_word = (17'(word_inc) == {1'b0, len_q});

   always_ff @(posedge Clk) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (xfer && is_sync) state_d = S_LEN_HI;
         S_LEN_HI: if (xfer) state_d = S_LEN_LO;
         S_LEN_LO: if (xfer) state_d = len_bad ? S_ERROR : S_DATA;
         S_DATA:   if (xfer && word_done && last_word) state_d = S_CHECK;
         S_CHECK:  if (xfer) state_d = (ByteIn == acc_q) ? S_IDLE : S_ERROR;
         S_ERROR:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      acc_d      = acc_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      run_d      = run_q;
      err_d      = err_q;
      ready_d    = (state_d != S_ERROR);
      case (state_q)
         S_IDLE: begin
            if (xfer && is_sync) begin
               run_d = 1'b0;
               err_d = 1'b0;
            end
         end
         S_LEN_HI: begin
            if (xfer) len_d[15:8] = ByteIn;
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = ByteIn;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               acc_d      = '0;
               if (len_bad) begin
                  err_d = 1'b1;
                  run_d = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               data_d = {data_q[23:0], ByteIn};
               acc_d  = acc_q ^ ByteIn;
               if (word_done) begin
                  we_d       = 1'b1;
                  addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                  wdata_d    = {data_q[23:0], ByteIn};
                  word_cnt_d = word_inc;
                  byte_cnt_d = '0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         S_CHECK: begin
            if (xfer) begin
               if (ByteIn == acc_q) begin
                  run_d = 1'b1;
               end else begin
                  err_d = 1'b1;
                  run_d = 1'b0;
               end
            end
         end
         S_ERROR: begin
            err_d = 1'b1;
            run_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         acc_q      <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         acc_q      <= acc_d;
         ready_q    <= ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         run_q      <= run_d;
         err_q      <= err_d;
      end
   end

   assign ByteReady = ready_q;
   assign ImemWE    = we_q;
   assign ImemAddr  = addr_q;
   assign ImemWData = wdata_q;
   assign CpuRun    = run_q;
   assign LoadErr   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: one instance at the default depth and one
// at ADDR_WIDTH=2 for the full-depth frame; expected writes are queued per instance.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] byte_in;
   logic       valid8, valid2;

   logic        ready8, we8, run8, err8;
   logic [7:0]  addr8;
   logic [31:0] wdata8;
   logic        ready2, we2, run2, err2;
   logic [1:0]  addr2;
   logic [31:0] wdata2;

   int checks = 0;
   int errors = 0;

   logic [39:0] exp_q8[$];
   logic [39:0] exp_q2[$];
   logic [39:0] exp8, exp2;
   logic [31:0] frame_words[4];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(8)) dut8 (
      .Clk(clk), .Reset_n(reset_n), .ByteIn(byte_in), .ByteValid(valid8),
      .ByteReady(ready8), .ImemWE(we8), .ImemAddr(addr8), .ImemWData(wdata8),
      .CpuRun(run8), .LoadErr(err8)
   );

   imem_loader #(.ADDR_WIDTH(2)) dut2 (
      .Clk(clk), .Reset_n(reset_n), .ByteIn(byte_in), .ByteValid(valid2),
      .ByteReady(ready2), .ImemWE(we2), .ImemAddr(addr2), .ImemWData(wdata2),
      .CpuRun(run2), .LoadErr(err2)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one byte until it is accepted; ready is sampled between edges.
   task automatic applyStimulus(input bit sel, input logic [7:0] b);
      logic rdy;
      bit   got = 1'b0;
      byte_in = b;
      if (sel) valid2 = 1'b1;
      else     valid8 = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         rdy = sel ? ready2 : ready8;
         @(posedge clk);
         #1;
         if (rdy) got = 1'b1;
      end
      valid8 = 1'b0;
      valid2 = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake timeout: byte 0x%0h not accepted, expected acceptance", b);
      end
   endtask

   task automatic gapCycle(input bit gap);
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendFrame(input bit sel, input int n, input logic [7:0] chk,
                            input bit gap, input bit check_sync);
      logic [15:0] len;
      logic [31:0] w;
      len = 16'(n);
      for (int i = 0; i < n; i++) begin
         if (sel) exp_q2.push_back({8'(i), frame_words[i]});
         else     exp_q8.push_back({8'(i), frame_words[i]});
      end
      applyStimulus(sel, 8'hA5);
      if (check_sync) begin
         @(negedge clk);
         checkOutput("sync clears LoadErr", 32'(sel ? err2 : err8), 32'd0);
         checkOutput("sync clears CpuRun", 32'(sel ? run2 : run8), 32'd0);
      end
      gapCycle(gap);
      applyStimulus(sel, len[15:8]);
      gapCycle(gap);
      applyStimulus(sel, len[7:0]);
      gapCycle(gap);
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         for (int k = 0; k < 4; k++) begin
            applyStimulus(sel, w[31-8*k -: 8]);
            gapCycle(gap);
         end
      end
      applyStimulus(sel, chk);
   endtask

   always @(negedge clk) begin
      if (we8) begin
         if (exp_q8.size() == 0) begin
            checkOutput("unexpected write dut8", 32'(we8), 32'd0);
         end else begin
            exp8 = exp_q8.pop_front();
            checkOutput("addr dut8", 32'(addr8), 32'(exp8[39:32]));
            checkOutput("wdata dut8", wdata8, exp8[31:0]);
         end
      end
      if (we2) begin
         if (exp_q2.size() == 0) begin
            checkOutput("unexpected write dut2", 32'(we2), 32'd0);
         end else begin
            exp2 = exp_q2.pop_front();
            checkOutput("addr dut2", 32'(addr2), 32'(exp2[39:32]));
            checkOutput("wdata dut2", wdata2, exp2[31:0]);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      valid8  = 1'b0;
      valid2  = 1'b0;
      byte_in = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset ByteReady", 32'(ready8), 32'd0);
      checkOutput("reset ImemWE", 32'(we8), 32'd0);
      checkOutput("reset CpuRun", 32'(run8), 32'd0);
      checkOutput("reset LoadErr", 32'(err8), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ready after reset dut8", 32'(ready8), 32'd1);
      checkOutput("ready after reset dut2", 32'(ready2), 32'd1);

      $display("[TB] nominal load");
      frame_words[0] = 32'h20080005;
      frame_words[1] = 32'h2009000A;
      sendFrame(1'b0, 2, 8'h0E, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("nominal CpuRun", 32'(run8), 32'd1);
      checkOutput("nominal LoadErr", 32'(err8), 32'd0);

      $display("[TB] checksum failure");
      sendFrame(1'b0, 2, 8'h0F, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("chk err ByteReady low", 32'(ready8), 32'd0);
      checkOutput("chk err LoadErr", 32'(err8), 32'd1);
      checkOutput("chk err CpuRun", 32'(run8), 32'd0);
      @(negedge clk);
      checkOutput("chk err ByteReady back", 32'(ready8), 32'd1);
      checkOutput("chk err LoadErr held", 32'(err8), 32'd1);

      $display("[TB] length errors");
      applyStimulus(1'b0, 8'hA5);
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h00);
      @(negedge clk);
      checkOutput("len0 ByteReady low", 32'(ready8), 32'd0);
      checkOutput("len0 LoadErr", 32'(err8), 32'd1);
      applyStimulus(1'b0, 8'hA5);
      applyStimulus(1'b0, 8'h01);
      applyStimulus(1'b0, 8'h01);
      @(negedge clk);
      checkOutput("len257 LoadErr", 32'(err8), 32'd1);
      checkOutput("len257 CpuRun", 32'(run8), 32'd0);
      sendFrame(1'b0, 2, 8'h0E, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("recovery CpuRun", 32'(run8), 32'd1);
      checkOutput("recovery LoadErr", 32'(err8), 32'd0);

      $display("[TB] throttled input with garbage");
      applyStimulus(1'b0, 8'h00);
      gapCycle(1'b1);
      applyStimulus(1'b0, 8'hFF);
      @(negedge clk);
      checkOutput("garbage keeps CpuRun", 32'(run8), 32'd1);
      gapCycle(1'b1);
      sendFrame(1'b0, 2, 8'h0E, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("throttled CpuRun", 32'(run8), 32'd1);
      checkOutput("throttled LoadErr", 32'(err8), 32'd0);

      $display("[TB] reset mid-word");
      applyStimulus(1'b0, 8'hA5);
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h02);
      applyStimulus(1'b0, 8'h20);
      applyStimulus(1'b0, 8'h08);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("midreset ImemWE", 32'(we8), 32'd0);
      checkOutput("midreset ImemAddr", 32'(addr8), 32'd0);
      checkOutput("midreset ImemWData", wdata8, 32'd0);
      checkOutput("midreset CpuRun", 32'(run8), 32'd0);
      checkOutput("midreset LoadErr", 32'(err8), 32'd0);
      checkOutput("midreset ByteReady", 32'(ready8), 32'd0);
      sendFrame(1'b0, 2, 8'h0E, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("post-reset load CpuRun", 32'(run8), 32'd1);

      $display("[TB] full depth and reload");
      frame_words[0] = 32'h00000001;
      frame_words[1] = 32'h10000002;
      frame_words[2] = 32'hDEADBEEF;
      frame_words[3] = 32'hA5A5A5A5;
      sendFrame(1'b1, 4, 8'h31, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("full depth CpuRun", 32'(run2), 32'd1);
      checkOutput("full depth LoadErr", 32'(err2), 32'd0);
      applyStimulus(1'b1, 8'hA5);
      @(negedge clk);
      checkOutput("reload drops CpuRun", 32'(run2), 32'd0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("pending writes dut8", 32'(exp_q8.size()), 32'd0);
      checkOutput("pending writes dut2", 32'(exp_q2.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the imem write port at word addresses 0..N-1. It holds the processor stopped until a complete frame with a correct checksum has been loaded, then releases it to fetch from PC = 0.

## Interface
Parameters:
- ADDR_WIDTH, 8, imem word-address width; imem depth = 2^ADDR_WIDTH words.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- ByteIn  in  8  incoming stream byte.
- ByteValid  in  1  ByteIn valid this cycle.
- ByteReady  out  1  loader accepts ByteIn; a byte transfers when ByteValid & ByteReady at the clock edge.
- ImemWE  out  1  one-cycle imem write strobe.
- ImemAddr  out  ADDR_WIDTH  imem word address.
- ImemWData  out  32  instruction word.
- CpuRun  out  1  1 = processor may run; 0 = processor held in reset.
- LoadErr  out  1  last frame rejected (length or checksum).

## Operation
- Frame: 0xA5 sync, LEN_HI, LEN_LO (N = 16-bit word count), 4N data bytes (MSB of each word first), CHK = XOR of all 4N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, ERROR.
- IDLE: non-0xA5 bytes are accepted and discarded. 0xA5 -> LEN_HI; same edge clears CpuRun and LoadErr.
- LEN_HI: capture the high byte -> LEN_LO.
- LEN_LO: capture the low byte. If N == 0 or N > 2^ADDR_WIDTH -> ERROR. Otherwise -> DATA; clear word counter, byte counter, and checksum accumulator.
- DATA: shift each byte into a 32-bit assembly register (data = {data[23:0], ByteIn}) and XOR it into the accumulator. After the 4th byte of a word, write the word, increment the word counter, and reset the byte counter. After word N-1 -> CHECK.
- CHECK: if the byte equals the accumulator, set CpuRun = 1 -> IDLE. On mismatch -> ERROR. Words already written stay in imem.
- ERROR: LoadErr = 1, CpuRun = 0 -> IDLE on the next edge. LoadErr stays set until the next sync byte.
- A new 0xA5 received in IDLE after a successful load restarts loading and drops CpuRun.
- Word counter is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH completes without wrap. ImemAddr = counter[ADDR_WIDTH-1:0].

## Timing
- Reset values (cycle after any edge with Reset_n = 0): state IDLE, ByteReady 0, ImemWE 0, ImemAddr 0, ImemWData 0, CpuRun 0, LoadErr 0, all counters and the accumulator 0.
- ByteReady is registered: 1 from the first cycle after reset release in every state except ERROR, where it is 0.
- Throughput: 1 byte per cycle sustained. ByteValid gaps are allowed anywhere; state holds while there is no transfer.
- Write latency: ImemWE, ImemAddr, and ImemWData are registered. They are asserted for exactly the one cycle following the edge that accepts the 4th byte of a word.
- CpuRun rises the cycle after the CHK byte is accepted. The last ImemWE occurs at least one cycle before that edge, so imem is fully written before the processor leaves reset.
- Reset mid-frame: abandons the frame, drops CpuRun, and suppresses any pending ImemWE. No partial word is written.
- Sync byte 0xA5 inside LEN or DATA is treated as ordinary data. It is not a resync.

## Test plan
- Nominal load, ADDR_WIDTH=8. Stream A5 00 02 20 08 00 05 20 09 00 0A 0E back-to-back. Expected: ImemWE pulses at addr 0 with data 0x20080005 and at addr 1 with data 0x2009000A; CpuRun goes to 1 one cycle after 0x0E is accepted; LoadErr = 0.
- Checksum failure. Same stream with CHK = 0x0F. Expected: both writes occur; CpuRun stays 0; LoadErr = 1; ByteReady = 0 for exactly one cycle.
- Length errors. Streams A5 00 00 and A5 01 01 (N = 257 > 256). Expected: no ImemWE in either case; LoadErr = 1; a following valid frame loads normally and clears LoadErr on its A5.
- Throttled input. Nominal stream with ByteValid toggled 1/0 every cycle plus garbage bytes 00 FF before A5. Expected: identical writes and CpuRun result; garbage is ignored.
- Reset mid-word. Hold Reset_n = 0 for one cycle after the 2nd data byte of word 0. Expected: no ImemWE; all outputs at reset values; a fresh nominal frame then loads correctly.
- Full depth and reload. Use ADDR_WIDTH=2, N=4, words 0..3. Expected: addresses 0..3 written, no wrap, CpuRun = 1. A second A5 drops CpuRun on the next cycle.
